// File: rtl/tx_iq_rate_interp_pkg.sv
// Shared types and constants for the TX I/Q rate interpolator.
// State encodings, minimum period length and the default component width.
package tx_iq_rate_interp_pkg;

  localparam int IQ_DATA_WIDTH_DEF = 16;
  localparam int RATE_DIV_MIN      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  function automatic logic [7:0] clamp_rate(input logic [7:0] rate);
    return (rate < 8'(RATE_DIV_MIN)) ? 8'(RATE_DIV_MIN) : rate;
  endfunction

endpackage

// File: rtl/tx_iq_rate_interp_midpoint.sv
// Signed average of two components, floored toward -inf; purely combinational.
// The sum carries one extra bit so no saturation is ever required.
module tx_iq_rate_interp_midpoint #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] mid
);

  logic signed [W:0] sum;

  assign sum = $signed({a[W-1], a}) + $signed({b[W-1], b});
  assign mid = W'(sum >>> 1);

endmodule

// File: rtl/tx_iq_rate_interp.sv
// Pulls one {Q,I} sample per rate_div clocks and emits two DAC samples per input
// (midpoint or hold), tracking FIFO underruns with a saturating counter and sticky flag.
module tx_iq_rate_interp
  import tx_iq_rate_interp_pkg::*;
#(
  parameter int IQ_DATA_WIDTH = IQ_DATA_WIDTH_DEF,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [7:0]                 rate_div,
  input  logic                       interp_en,
  input  logic                       iq_swap,
  input  logic                       underrun_clr,
  input  logic [2*IQ_DATA_WIDTH-1:0] in_iq_pack,
  input  logic                       in_iq_valid,
  input  logic                       fifo_empty,
  output logic                       in_iq_ready,
  output logic [2*IQ_DATA_WIDTH-1:0] dac_iq,
  output logic                       dac_iq_valid,
  output logic [CNT_WIDTH-1:0]       underrun_cnt,
  output logic                       underrun_flag
);

  localparam int IQW = IQ_DATA_WIDTH;
  localparam int PW  = 2 * IQ_DATA_WIDTH;

  state_t        state;
  logic [7:0]    cnt;
  logic [7:0]    per_len;
  logic [7:0]    second_cnt;
  logic [PW-1:0] cur;
  logic [PW-1:0] prev;
  logic [PW-1:0] sample;
  logic [PW-1:0] captured;
  logic [PW-1:0] mid_iq;
  logic [PW-1:0] out_pt;
  logic          underrun;
  logic          period_end;
  logic          first_pt;
  logic          second_pt;

  tx_iq_rate_interp_midpoint #(.W(IQW)) u_mid_i (
    .a   (prev[IQW-1:0]),
    .b   (cur[IQW-1:0]),
    .mid (mid_iq[IQW-1:0])
  );

  tx_iq_rate_interp_midpoint #(.W(IQW)) u_mid_q (
    .a   (prev[PW-1:IQW]),
    .b   (cur[PW-1:IQW]),
    .mid (mid_iq[PW-1:IQW])
  );

  // With a 2-clock period the direct sample lands on cnt==0 of the following period.
  always_comb begin
    sample     = iq_swap ? {in_iq_pack[IQW-1:0], in_iq_pack[PW-1:IQW]} : in_iq_pack;
    underrun   = in_iq_ready && fifo_empty;
    captured   = underrun ? '0 : (in_iq_valid ? sample : cur);
    period_end = (cnt == per_len - 8'd1);
    second_cnt = (per_len == 8'd2) ? 8'd0 : (per_len >> 1) + 8'd1;
    first_pt   = (cnt == 8'd1);
    second_pt  = (cnt == second_cnt);
    out_pt     = (interp_en && first_pt) ? mid_iq : cur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      per_len       <= 8'(RATE_DIV_MIN);
      cur           <= '0;
      prev          <= '0;
      in_iq_ready   <= 1'b0;
      dac_iq        <= '0;
      dac_iq_valid  <= 1'b0;
      underrun_cnt  <= '0;
      underrun_flag <= 1'b0;
    end else begin
      if (underrun_clr) begin
        underrun_cnt  <= '0;
        underrun_flag <= 1'b0;
      end else if (underrun) begin
        underrun_flag <= 1'b1;
        if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          in_iq_ready  <= 1'b0;
          dac_iq       <= '0;
          dac_iq_valid <= 1'b0;
          if (enable && !fifo_empty) begin
            state       <= ST_PRIME;
            in_iq_ready <= 1'b1;
          end
        end

        ST_PRIME: begin
          in_iq_ready  <= 1'b0;
          dac_iq_valid <= 1'b0;
          cur          <= captured;
          prev         <= '0;
          per_len      <= clamp_rate(rate_div);
          cnt          <= 8'd1;
          state        <= ST_RUN;
        end

        ST_RUN: begin
          dac_iq_valid <= first_pt || second_pt;
          if (first_pt || second_pt) dac_iq <= out_pt;
          if (in_iq_ready) begin
            prev    <= cur;
            cur     <= captured;
            per_len <= clamp_rate(rate_div);
          end
          if (period_end) begin
            cnt <= '0;
            if (!enable) begin
              state       <= ST_IDLE;
              in_iq_ready <= 1'b0;
              if (!(first_pt || second_pt)) dac_iq <= '0;
            end else begin
              in_iq_ready <= 1'b1;
            end
          end else begin
            cnt         <= cnt + 8'd1;
            in_iq_ready <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_iq_rate_interp.sv
// Directed bench for tx_iq_rate_interp: a queue-backed FIFO model feeds the DUT and
// a negedge monitor records read strobes and DAC pulses with their cycle numbers.
module tb_tx_iq_rate_interp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  rate_div = 8'd4;
  logic        interp_en = 1'b0;
  logic        iq_swap = 1'b0;
  logic        underrun_clr = 1'b0;
  logic [31:0] in_iq_pack = '0;
  logic        in_iq_valid = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        in_iq_ready;
  logic [31:0] dac_iq;
  logic        dac_iq_valid;
  logic [15:0] underrun_cnt;
  logic        underrun_flag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic        last_rdy = 1'b0;
  logic [31:0] fq[$];
  int          rdy_t[$];
  logic [31:0] out_d[$];
  int          out_t[$];

  tx_iq_rate_interp #(.IQ_DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .rate_div      (rate_div),
    .interp_en     (interp_en),
    .iq_swap       (iq_swap),
    .underrun_clr  (underrun_clr),
    .in_iq_pack    (in_iq_pack),
    .in_iq_valid   (in_iq_valid),
    .fifo_empty    (fifo_empty),
    .in_iq_ready   (in_iq_ready),
    .dac_iq        (dac_iq),
    .dac_iq_valid  (dac_iq_valid),
    .underrun_cnt  (underrun_cnt),
    .underrun_flag (underrun_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO head pops one negedge after the strobe cycle, i.e. after the DUT captured it.
  always @(negedge clk) begin
    if (last_rdy && fq.size() > 0) void'(fq.pop_front());
    last_rdy = in_iq_ready;
    if (in_iq_ready) rdy_t.push_back(cyc);
    if (dac_iq_valid) begin
      out_d.push_back(dac_iq);
      out_t.push_back(cyc);
    end
    in_iq_valid = (fq.size() > 0);
    fifo_empty  = (fq.size() == 0);
    in_iq_pack  = (fq.size() > 0) ? fq[0] : 32'h0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    @(posedge clk);
    rdy_t.delete();
    out_d.delete();
    out_t.delete();
  endtask

  task automatic load(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2, input int n);
    @(posedge clk);
    if (n > 0) fq.push_back(s0);
    if (n > 1) fq.push_back(s1);
    if (n > 2) fq.push_back(s2);
    idle(2);
  endtask

  task automatic wait_ready(input string name, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (in_iq_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no read strobe within %0d cycles (required one)", name, max);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++; if (in_iq_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_iq_ready); end
    checks++; if (dac_iq !== 32'h0) begin errors++; $display("FAIL reset_dac: got %h want 0", dac_iq); end
    checks++; if (dac_iq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dac_iq_valid); end
    checks++; if (underrun_cnt !== 16'h0) begin errors++; $display("FAIL reset_ucnt: got %0d want 0", underrun_cnt); end
    checks++; if (underrun_flag !== 1'b0) begin errors++; $display("FAIL reset_uflag: got %b want 0", underrun_flag); end
    rst = 1'b0;
    idle(3);
    checks++; if (in_iq_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", in_iq_ready); end
  endtask

  task automatic test_interp_rate10();
    logic [31:0] exp [6];
    exp = '{32'd50, 32'd100, 32'd150, 32'd200, 32'd250, 32'd300};
    rate_div = 8'd10; interp_en = 1'b1; iq_swap = 1'b0;
    load(32'd100, 32'd200, 32'd300, 3);
    clear_mon();
    @(negedge clk); enable = 1'b1;
    idle(25);
    enable = 1'b0;
    idle(15);
    checks++; if (rdy_t.size() !== 3) begin errors++; $display("FAIL r10_strobes: got %0d want 3", rdy_t.size()); end
    checks++; if (rdy_t[1] - rdy_t[0] !== 10) begin errors++; $display("FAIL r10_gap1: got %0d want 10", rdy_t[1] - rdy_t[0]); end
    checks++; if (rdy_t[2] - rdy_t[1] !== 10) begin errors++; $display("FAIL r10_gap2: got %0d want 10", rdy_t[2] - rdy_t[1]); end
    checks++; if (out_d.size() !== 6) begin errors++; $display("FAIL r10_count: got %0d want 6", out_d.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_d[i] !== exp[i]) begin errors++; $display("FAIL r10_out%0d: got %h want %h", i, out_d[i], exp[i]); end
    end
    checks++; if (out_t[0] - rdy_t[0] !== 2) begin errors++; $display("FAIL r10_lat_mid: got %0d want 2", out_t[0] - rdy_t[0]); end
    checks++; if (out_t[1] - rdy_t[0] !== 7) begin errors++; $display("FAIL r10_lat_direct: got %0d want 7", out_t[1] - rdy_t[0]); end
    checks++; if (dac_iq !== 32'h0) begin errors++; $display("FAIL r10_idle_dac: got %h want 0", dac_iq); end
    checks++; if (underrun_cnt !== 16'h0) begin errors++; $display("FAIL r10_ucnt: got %0d want 0", underrun_cnt); end
  endtask

  task automatic test_hold_and_floor();
    logic [31:0] exp_h [4];
    logic [31:0] exp_f [4];
    exp_h = '{32'h0000FFF8, 32'h0000FFF8, 32'h00000008, 32'h00000008};
    exp_f = '{32'h0000FFFE, 32'h0000FFFD, 32'h0000FFFE, 32'h00000000};
    rate_div = 8'd4; interp_en = 1'b0;
    load(32'h0000FFF8, 32'h00000008, 32'h0, 2);
    clear_mon();
    @(negedge clk); enable = 1'b1;
    idle(5);
    enable = 1'b0;
    idle(8);
    checks++; if (out_d.size() !== 4) begin errors++; $display("FAIL zoh_count: got %0d want 4", out_d.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_d[i] !== exp_h[i]) begin errors++; $display("FAIL zoh_out%0d: got %h want %h", i, out_d[i], exp_h[i]); end
    end
    interp_en = 1'b1;
    load(32'h0000FFFD, 32'h00000000, 32'h0, 2);
    clear_mon();
    @(negedge clk); enable = 1'b1;
    idle(5);
    enable = 1'b0;
    idle(8);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_d[i] !== exp_f[i]) begin errors++; $display("FAIL floor_out%0d: got %h want %h", i, out_d[i], exp_f[i]); end
    end
  endtask

  task automatic test_underrun();
    logic [31:0] exp [6];
    exp = '{32'd10, 32'd10, 32'd20, 32'd20, 32'd0, 32'd0};
    rate_div = 8'd4; interp_en = 1'b0;
    load(32'd10, 32'd20, 32'h0, 2);
    clear_mon();
    @(negedge clk); enable = 1'b1;
    idle(9);
    enable = 1'b0;
    idle(8);
    checks++; if (out_d.size() !== 6) begin errors++; $display("FAIL ur_count: got %0d want 6", out_d.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_d[i] !== exp[i]) begin errors++; $display("FAIL ur_out%0d: got %h want %h", i, out_d[i], exp[i]); end
    end
    checks++; if (underrun_cnt !== 16'd1) begin errors++; $display("FAIL ur_cnt: got %0d want 1", underrun_cnt); end
    checks++; if (underrun_flag !== 1'b1) begin errors++; $display("FAIL ur_flag: got %b want 1", underrun_flag); end

    // rate_div=1 behaves as a 2-clock period; clear lands on the cycle of a new underrun
    rate_div = 8'd1;
    load(32'd5, 32'h0, 32'h0, 1);
    clear_mon();
    @(negedge clk); enable = 1'b1;
    wait_ready("clr_first_strobe", 20);
    wait_ready("clr_second_strobe", 20);
    underrun_clr = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    underrun_clr = 1'b0;
    checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", underrun_cnt); end
    checks++; if (underrun_flag !== 1'b0) begin errors++; $display("FAIL clr_flag: got %b want 0", underrun_flag); end
    checks++; if (rdy_t[1] - rdy_t[0] !== 2) begin errors++; $display("FAIL rate1_gap: got %0d want 2", rdy_t[1] - rdy_t[0]); end
    idle(6);
    checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL clr_after: got %0d want 0", underrun_cnt); end
  endtask

  task automatic test_rate_change();
    rate_div = 8'd10; interp_en = 1'b0;
    load(32'd1, 32'd2, 32'd3, 3);
    @(posedge clk); fq.push_back(32'd4);
    idle(2);
    clear_mon();
    @(negedge clk); enable = 1'b1;
    wait_ready("rc_strobe1", 20);
    idle(3);
    rate_div = 8'd6;
    wait_ready("rc_strobe2", 20);
    idle(2);
    rate_div = 8'd0;
    wait_ready("rc_strobe3", 20);
    wait_ready("rc_strobe4", 20);
    enable = 1'b0;
    idle(8);
    checks++; if (rdy_t.size() !== 4) begin errors++; $display("FAIL rc_strobes: got %0d want 4", rdy_t.size()); end
    checks++; if (rdy_t[1] - rdy_t[0] !== 10) begin errors++; $display("FAIL rc_gap1: got %0d want 10", rdy_t[1] - rdy_t[0]); end
    checks++; if (rdy_t[2] - rdy_t[1] !== 6) begin errors++; $display("FAIL rc_gap2: got %0d want 6", rdy_t[2] - rdy_t[1]); end
    checks++; if (rdy_t[3] - rdy_t[2] !== 2) begin errors++; $display("FAIL rc_gap3: got %0d want 2", rdy_t[3] - rdy_t[2]); end
    checks++; if (out_d.size() !== 7) begin errors++; $display("FAIL rc_count: got %0d want 7", out_d.size()); end
    checks++; if (out_d[5] !== 32'd3) begin errors++; $display("FAIL rc_len2_second: got %h want 3", out_d[5]); end
    checks++; if (out_d[6] !== 32'd4) begin errors++; $display("FAIL rc_last: got %h want 4", out_d[6]); end
  endtask

  task automatic test_enable_drop();
    logic [31:0] exp [4];
    exp = '{32'd500, 32'd1000, 32'd1500, 32'd2000};
    rate_div = 8'd8; interp_en = 1'b1;
    load(32'd1000, 32'd2000, 32'd3000, 3);
    clear_mon();
    @(negedge clk); enable = 1'b1;
    wait_ready("ed_strobe1", 20);
    wait_ready("ed_strobe2", 20);
    idle(3);
    enable = 1'b0;
    idle(12);
    checks++; if (rdy_t.size() !== 2) begin errors++; $display("FAIL ed_strobes: got %0d want 2", rdy_t.size()); end
    checks++; if (out_d.size() !== 4) begin errors++; $display("FAIL ed_count: got %0d want 4", out_d.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_d[i] !== exp[i]) begin errors++; $display("FAIL ed_out%0d: got %h want %h", i, out_d[i], exp[i]); end
    end
    checks++; if (dac_iq !== 32'h0) begin errors++; $display("FAIL ed_idle_dac: got %h want 0", dac_iq); end
    @(posedge clk); fq.delete();
    idle(2);
    enable = 1'b1;
    clear_mon();
    idle(10);
    checks++; if (rdy_t.size() !== 0) begin errors++; $display("FAIL ed_empty_strobes: got %0d want 0", rdy_t.size()); end
    checks++; if (dac_iq_valid !== 1'b0) begin errors++; $display("FAIL ed_empty_valid: got %b want 0", dac_iq_valid); end
    enable = 1'b0;
    idle(2);
  endtask

  task automatic test_reset_swap();
    rate_div = 8'd4; interp_en = 1'b0; iq_swap = 1'b1;
    load(32'h0007_0003, 32'h0, 32'h0, 1);
    clear_mon();
    @(negedge clk); enable = 1'b1;
    wait_ready("sw_strobe1", 20);
    idle(2);
    checks++; if (dac_iq !== 32'h0003_0007) begin errors++; $display("FAIL swap_order: got %h want 00030007", dac_iq); end
    checks++; if (dac_iq_valid !== 1'b1) begin errors++; $display("FAIL swap_valid: got %b want 1", dac_iq_valid); end
    wait_ready("sw_strobe2", 20);
    idle(2);
    checks++; if (underrun_cnt !== 16'd1) begin errors++; $display("FAIL pre_rst_ucnt: got %0d want 1", underrun_cnt); end
    rst = 1'b1;
    idle(1);
    checks++; if (in_iq_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", in_iq_ready); end
    checks++; if (dac_iq !== 32'h0) begin errors++; $display("FAIL mid_rst_dac: got %h want 0", dac_iq); end
    checks++; if (dac_iq_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", dac_iq_valid); end
    checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_ucnt: got %0d want 0", underrun_cnt); end
    checks++; if (underrun_flag !== 1'b0) begin errors++; $display("FAIL mid_rst_uflag: got %b want 0", underrun_flag); end
    enable = 1'b0;
    rst = 1'b0;
    idle(4);
    checks++; if (in_iq_ready !== 1'b0) begin errors++; $display("FAIL post_rst_ready: got %b want 0", in_iq_ready); end
  endtask

  initial begin
    test_reset();
    test_interp_rate10();
    test_hold_and_floor();
    test_underrun();
    test_rate_change();
    test_enable_drop();
    test_reset_swap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
